// File: rtl/adrv9001_ssi_pkg.sv
// rtl/adrv9001_ssi_pkg.sv - shared states, PRBS15 constants and frame sizing for the SSI frame transmitter
package adrv9001_ssi_pkg;

  localparam logic [1:0] ST_DISABLED  = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  // PRBS15: x^15 + x^14 + 1, feedback taken from the two top state bits
  localparam int         PRBS15_LEN    = 15;
  localparam int         PRBS15_TAP_HI = 14;
  localparam int         PRBS15_TAP_LO = 13;
  localparam logic [14:0] PRBS15_SEED  = 15'h7FFF;

  function automatic int frame_bits(input int data_width, input int single_lane);
    return (single_lane != 0) ? 2 * data_width : data_width;
  endfunction

endpackage

// File: rtl/adrv9001_ssi_prbs15.sv
// rtl/adrv9001_ssi_prbs15.sv - word-parallel PRBS15 step producing DATA_WIDTH bits, MSB first
module adrv9001_ssi_prbs15
  import adrv9001_ssi_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [PRBS15_LEN-1:0] state_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic [PRBS15_LEN-1:0] state_o
);

  logic [PRBS15_LEN-1:0] s;
  logic                  fb;

  // Unrolled LFSR: each feedback bit is shifted in and is also the next output bit.
  always_comb begin
    s      = state_i;
    fb     = 1'b0;
    word_o = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      fb                     = s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO];
      word_o[DATA_WIDTH-1-k] = fb;
      s                      = {s[PRBS15_LEN-2:0], fb};
    end
    state_o = s;
  end

endmodule

// File: rtl/adrv9001_ssi_frame_tx.sv
// rtl/adrv9001_ssi_frame_tx.sv - SSI frame transmitter, I/Q stream to strobe + SDR lanes; PRBS source under ADRV9001_SSI_TX_PRBS_EN
module adrv9001_ssi_frame_tx
  import adrv9001_ssi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    SINGLE_LANE = 1,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_enable,
  input  logic                  cfg_strobe_long,
  input  logic                  cfg_prbs_en,
  input  logic                  mssi_sync,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_i,
  input  logic [DATA_WIDTH-1:0] s_q,
  output logic                  out_strobe,
  output logic                  out_idata,
  output logic                  out_qdata,
  output logic                  out_active,
  output logic [15:0]           underflow_cnt
);

  localparam int            FRAME_BITS = frame_bits(DATA_WIDTH, SINGLE_LANE);
  localparam int            CW         = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(FRAME_BITS / 2);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mssi_sync_q;
  logic [FRAME_BITS-1:0] sr_i_q, sr_i_d;
  logic [DATA_WIDTH-1:0] sr_qlane_q, sr_qlane_d;
  logic                  strobe_q, strobe_d;
  logic                  active_q;
  logic [15:0]           uf_q, uf_d;

  logic                  sync_edge;
  logic                  load_slot;
  logic                  prbs_sel;
  logic [DATA_WIDTH-1:0] prbs_w_i, prbs_w_q;
  logic [DATA_WIDTH-1:0] ld_i, ld_q;
  logic                  underflow;
  logic [FRAME_BITS-1:0] frame_word;

  assign sync_edge = mssi_sync & ~mssi_sync_q;
  assign load_slot = cfg_enable &&
                     (((state_q == ST_WAIT_SYNC) && sync_edge) ||
                      ((state_q == ST_RUN) && ((cnt_q == CNT_LAST) || sync_edge)));
  assign s_ready   = load_slot && !prbs_sel;

`ifdef ADRV9001_SSI_TX_PRBS_EN
  logic [PRBS15_LEN-1:0] prbs_q, prbs_mid, prbs_next;

  assign prbs_sel = cfg_prbs_en;

  adrv9001_ssi_prbs15 #(.DATA_WIDTH(DATA_WIDTH)) u_prbs_i (
    .state_i (prbs_q),
    .word_o  (prbs_w_i),
    .state_o (prbs_mid)
  );

  adrv9001_ssi_prbs15 #(.DATA_WIDTH(DATA_WIDTH)) u_prbs_q (
    .state_i (prbs_mid),
    .word_o  (prbs_w_q),
    .state_o (prbs_next)
  );

  // Generator restarts from the seed whenever the block is disabled; advances two words per PRBS frame.
  always_ff @(posedge clk) begin
    if (!resetn || !cfg_enable || (state_q == ST_DISABLED)) begin
      prbs_q <= PRBS15_SEED;
    end else if (load_slot && prbs_sel) begin
      prbs_q <= prbs_next;
    end
  end
`else
  logic unused_prbs_en;

  assign unused_prbs_en = cfg_prbs_en;
  assign prbs_sel       = 1'b0;
  assign prbs_w_i       = '0;
  assign prbs_w_q       = '0;
`endif

  // Pick the word for a load slot: PRBS, the offered sample, or the idle word on underflow.
  always_comb begin
    ld_i      = IDLE_VALUE;
    ld_q      = IDLE_VALUE;
    underflow = 1'b0;
    if (prbs_sel) begin
      ld_i = prbs_w_i;
      ld_q = prbs_w_q;
    end else if (s_valid) begin
      ld_i = s_i;
      ld_q = s_q;
    end else begin
      underflow = 1'b1;
    end
  end

  generate
    if (SINGLE_LANE != 0) begin : g_single
      assign frame_word = {ld_i, ld_q};
    end else begin : g_dual
      assign frame_word = ld_i;
    end
  endgenerate

  // Next-state: FSM, frame counter, shift registers and saturating underflow count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_i_d     = sr_i_q;
    sr_qlane_d = sr_qlane_q;
    uf_d       = uf_q;
    if (!cfg_enable) begin
      state_d    = ST_DISABLED;
      cnt_d      = '0;
      sr_i_d     = '0;
      sr_qlane_d = '0;
    end else begin
      case (state_q)
        ST_DISABLED:  state_d = ST_WAIT_SYNC;
        ST_WAIT_SYNC: if (sync_edge) state_d = ST_RUN;
        ST_RUN:       state_d = ST_RUN;
        default:      state_d = ST_DISABLED;
      endcase
      if (load_slot) begin
        cnt_d      = '0;
        sr_i_d     = frame_word;
        sr_qlane_d = ld_q;
        if (underflow && (uf_q != 16'hFFFF)) uf_d = uf_q + 16'd1;
      end else if (state_q == ST_RUN) begin
        cnt_d      = cnt_q + CW'(1);
        sr_i_d     = {sr_i_q[FRAME_BITS-2:0], 1'b0};
        sr_qlane_d = {sr_qlane_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // Strobe is decoded from the counter value that will be on the lanes next cycle, then registered.
  assign strobe_d = (state_d == ST_RUN) &&
                    (cfg_strobe_long ? (cnt_d < CNT_HALF) : (cnt_d == '0));

  // State registers; lanes come straight from flops so they are glitch-free.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_DISABLED;
      cnt_q       <= '0;
      mssi_sync_q <= 1'b0;
      sr_i_q      <= '0;
      sr_qlane_q  <= '0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
      uf_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mssi_sync_q <= mssi_sync;
      sr_i_q      <= sr_i_d;
      sr_qlane_q  <= sr_qlane_d;
      strobe_q    <= strobe_d;
      active_q    <= (state_d == ST_RUN);
      uf_q        <= uf_d;
    end
  end

  assign out_strobe    = strobe_q;
  assign out_idata     = sr_i_q[FRAME_BITS-1];
  assign out_qdata     = (SINGLE_LANE != 0) ? 1'b0 : sr_qlane_q[DATA_WIDTH-1];
  assign out_active    = active_q;
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_adrv9001_ssi_frame_tx.sv
// tb/tb_adrv9001_ssi_frame_tx.sv - self-checking bench: lane 0 single-lane (32-bit frames), lane 1 two-lane (16-bit frames)
module tb_adrv9001_ssi_frame_tx;

  localparam logic [15:0] IDLE = 16'h5AC3;
`ifdef ADRV9001_SSI_TX_PRBS_EN
  localparam bit PRBS_BUILD = 1'b1;
`else
  localparam bit PRBS_BUILD = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        en[2], slong[2], pen[2], sync[2], sv[2];
  logic [15:0] si[2], sq[2];
  logic        rdy[2], stb[2], idat[2], qdat[2], act[2];
  logic [15:0] ufc[2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    adrv9001_ssi_frame_tx #(
      .DATA_WIDTH  (16),
      .SINGLE_LANE ((g == 0) ? 1 : 0),
      .IDLE_VALUE  (IDLE)
    ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .cfg_enable      (en[g]),
      .cfg_strobe_long (slong[g]),
      .cfg_prbs_en     (pen[g]),
      .mssi_sync       (sync[g]),
      .s_valid         (sv[g]),
      .s_ready         (rdy[g]),
      .s_i             (si[g]),
      .s_q             (sq[g]),
      .out_strobe      (stb[g]),
      .out_idata       (idat[g]),
      .out_qdata       (qdat[g]),
      .out_active      (act[g]),
      .underflow_cnt   (ufc[g])
    );
  end

  task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lane%0d t=%0t got %h expected %h", name, g, $time, got, exp);
    end
  endtask

  // Reference model: frame mode, bit position on the lanes, loaded frame words, underflow count.
  int          m_mode[2];
  int          m_pos[2];
  int          m_uf[2];
  logic [31:0] m_fi[2];
  logic [15:0] m_fq[2];
  logic        m_sprev[2], m_stb[2], m_i[2], m_q[2], m_act[2];
  logic [14:0] m_prbs[2];
  bit          m_vld = 1'b0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int          fb;
      logic        edge_s, slot, usep, nb;
      logic [15:0] wi, wq;
      logic [31:0] w;
      fb = (g == 0) ? 32 : 16;
      if (m_vld) begin
        chk("strobe", g, 32'(stb[g]), 32'(m_stb[g]));
        chk("idata", g, 32'(idat[g]), 32'(m_i[g]));
        chk("qdata", g, 32'(qdat[g]), 32'(m_q[g]));
        chk("active", g, 32'(act[g]), 32'(m_act[g]));
        chk("underflow_cnt", g, 32'(ufc[g]), 32'(m_uf[g]));
      end
      if (!resetn) begin
        m_mode[g] = 0; m_pos[g] = 0; m_uf[g] = 0; m_fi[g] = '0; m_fq[g] = '0;
        m_sprev[g] = 1'b0; m_prbs[g] = 15'h7FFF;
      end else begin
        edge_s = sync[g] & ~m_sprev[g];
        slot = en[g] && (((m_mode[g] == 1) && edge_s) ||
                         ((m_mode[g] == 2) && ((m_pos[g] == fb - 1) || edge_s)));
        usep = PRBS_BUILD && pen[g];
        if (m_vld) chk("s_ready", g, 32'(rdy[g]), 32'(slot && !usep));
        m_sprev[g] = sync[g];
        if (!en[g]) begin
          m_mode[g] = 0; m_pos[g] = 0; m_prbs[g] = 15'h7FFF;
        end else if (m_mode[g] == 0) begin
          m_mode[g] = 1; m_prbs[g] = 15'h7FFF;
        end else if (slot) begin
          if (usep) begin
            w = '0;
            for (int k = 0; k < 32; k++) begin
              nb = m_prbs[g][14] ^ m_prbs[g][13];
              w = {w[30:0], nb};
              m_prbs[g] = {m_prbs[g][13:0], nb};
            end
            wi = w[31:16]; wq = w[15:0];
          end else if (sv[g]) begin
            wi = si[g]; wq = sq[g];
          end else begin
            wi = IDLE; wq = IDLE;
            if (m_uf[g] < 65535) m_uf[g] = m_uf[g] + 1;
          end
          if (g == 0) begin m_fi[g] = {wi, wq}; m_fq[g] = '0; end
          else begin m_fi[g] = {16'h0000, wi}; m_fq[g] = wq; end
          m_mode[g] = 2; m_pos[g] = 0;
        end else if (m_mode[g] == 2) begin
          m_pos[g] = m_pos[g] + 1;
        end
      end
      m_act[g] = (m_mode[g] == 2);
      m_stb[g] = m_act[g] && (slong[g] ? (m_pos[g] < fb / 2) : (m_pos[g] == 0));
      m_i[g]   = m_act[g] ? m_fi[g][fb-1-m_pos[g]] : 1'b0;
      m_q[g]   = (m_act[g] && (g == 1)) ? m_fq[g][15-m_pos[g]] : 1'b0;
    end
    if (!resetn) m_vld = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int g, input logic [15:0] i, input logic [15:0] q);
    bit got;
    got = 1'b0;
    sv[g] = 1'b1; si[g] = i; sq[g] = q;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (rdy[g]) got = 1'b1;
    end
    chk("accept_wait", g, 32'(got), 32'd1);
    tick();
    sv[g] = 1'b0; sync[g] = 1'b0;
  endtask

  logic [31:0] ib, sb;
  logic [15:0] qb;
  int          nr;

  task automatic capture(input int g, input int n);
    ib = '0; sb = '0; qb = '0; nr = 0;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      ib = {ib[30:0], idat[g]};
      sb = {sb[30:0], stb[g]};
      qb = {qb[14:0], qdat[g]};
      nr += int'(rdy[g]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    for (int g = 0; g < 2; g++) begin
      en[g] = 0; slong[g] = 0; pen[g] = 0; sync[g] = 0; sv[g] = 0; si[g] = '0; sq[g] = '0;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_active", g, 32'(act[g]), 0);
      chk("rst_strobe", g, 32'(stb[g]), 0);
      chk("rst_idata", g, 32'(idat[g]), 0);
      chk("rst_ready", g, 32'(rdy[g]), 0);
      chk("rst_uf", g, 32'(ufc[g]), 0);
    end
    tick();
    resetn = 1'b1;

    // two-lane, pulse strobe
    en[1] = 1'b1;
    tick(); tick();
    sync[1] = 1'b1;
    send_frame(1, 16'hA55A, 16'h0FF0);
    capture(1, 16);
    chk("t1_idata", 1, ib, 32'h0000A55A);
    chk("t1_qdata", 1, 32'(qb), 32'h00000FF0);
    chk("t1_strobe", 1, sb, 32'h00008000);
    chk("t1_ready_cnt", 1, 32'(nr), 1);

    // single-lane, long strobe
    tick();
    en[0] = 1'b1; slong[0] = 1'b1;
    tick(); tick();
    sync[0] = 1'b1;
    send_frame(0, 16'h8001, 16'h7FFE);
    capture(0, 32);
    chk("t2_idata", 0, ib, 32'h80017FFE);
    chk("t2_strobe", 0, sb, 32'hFFFF0000);
    chk("t2_qdata", 0, 32'(qb), 0);
    chk("t2_ready_cnt", 0, 32'(nr), 1);

    // underflow: three idle frames while s_valid stays low
    repeat (94) tick();
    @(negedge clk);
    chk("t3_uf", 0, 32'(ufc[0]), 3);
    chk("t3_active", 0, 32'(act[0]), 1);

    // enable drop mid-frame, then re-enable waits for sync
    tick();
    en[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_dis_active", 0, 32'(act[0]), 0);
    chk("t5_dis_idata", 0, 32'(idat[0]), 0);
    chk("t5_dis_strobe", 0, 32'(stb[0]), 0);
    tick();
    en[0] = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t5_wait_active", 0, 32'(act[0]), 0);
    chk("t5_wait_ready", 0, 32'(rdy[0]), 0);
    tick();
    sync[0] = 1'b1;
    send_frame(0, 16'h1234, 16'hFEDC);
    capture(0, 32);
    chk("t5_resync_idata", 0, ib, 32'h1234FEDC);
    tick();
    en[0] = 1'b0;

    // sync pulse at bit 7 aborts the frame; then sync edge on the last bit loads once
    send_frame(1, 16'hC3A5, 16'h5A3C);
    repeat (7) tick();
    sync[1] = 1'b1; sv[1] = 1'b1; si[1] = 16'h8421; sq[1] = 16'hF00F;
    @(negedge clk);
    chk("t4_sync_ready", 1, 32'(rdy[1]), 1);
    tick();
    sv[1] = 1'b0;
    ib = '0; qb = '0; nr = 0;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      ib = {ib[30:0], idat[1]};
      qb = {qb[14:0], qdat[1]};
      nr += int'(rdy[1]);
      tick();
      if (b == 13) sync[1] = 1'b0;
      if (b == 14) begin
        sync[1] = 1'b1; sv[1] = 1'b1; si[1] = 16'h0F0F; sq[1] = 16'hF0F0;
      end
    end
    sv[1] = 1'b0;
    chk("t4_idata", 1, ib, 32'h00008421);
    chk("t4_qdata", 1, 32'(qb), 32'h0000F00F);
    chk("t4_ready_cnt", 1, 32'(nr), 1);
    capture(1, 16);
    chk("t4_last_idata", 1, ib, 32'h00000F0F);
    chk("t4_last_qdata", 1, 32'(qb), 32'h0000F0F0);

`ifdef ADRV9001_SSI_TX_PRBS_EN
    tick();
    pen[1] = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("t6_prbs_ready", 1, 32'(rdy[1]), 0);
    end
    tick();
    pen[1] = 1'b0;
`endif

    // reset mid-frame
    tick();
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("t5_rst_active", g, 32'(act[g]), 0);
      chk("t5_rst_idata", g, 32'(idat[g]), 0);
      chk("t5_rst_qdata", g, 32'(qdat[g]), 0);
      chk("t5_rst_strobe", g, 32'(stb[g]), 0);
      chk("t5_rst_uf", g, 32'(ufc[g]), 0);
    end
    tick();
    resetn = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
